// File: rtl/bp_common_cfg_link_pkg.sv
// Shared types for the tile config link: memory-message format, config-space
// offsets, mode encodings and the address decoder used by the responder.
package bp_common_cfg_link_pkg;

  localparam int paddr_width_gp       = 40;
  localparam int cce_block_width_gp   = 64;
  localparam int mem_payload_width_gp = 16;

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'd0,
    e_cce_mem_wr    = 4'd1,
    e_cce_mem_uc_rd = 4'd2,
    e_cce_mem_uc_wr = 4'd3,
    e_cce_mem_pre   = 4'd4,
    e_cce_mem_wb    = 4'd5
  } bp_cce_mem_cmd_type_e;

  typedef struct packed {
    bp_cce_mem_cmd_type_e              msg_type;
    logic [paddr_width_gp-1:0]         addr;
    logic [2:0]                        size;
    logic [mem_payload_width_gp-1:0]   payload;
    logic [cce_block_width_gp-1:0]     data;
  } bp_cce_mem_msg_s;

  localparam logic [15:0] cfg_addr_freeze_gp      = 16'h0004;
  localparam logic [15:0] cfg_addr_core_id_gp     = 16'h0008;
  localparam logic [15:0] cfg_addr_cce_id_gp      = 16'h000C;
  localparam logic [15:0] cfg_addr_cce_mode_gp    = 16'h0010;
  localparam logic [15:0] cfg_addr_icache_mode_gp = 16'h0014;
  localparam logic [15:0] cfg_addr_dcache_mode_gp = 16'h0018;
  localparam logic [15:0] cfg_ucode_base_gp       = 16'h8000;

  typedef enum logic {
    e_cce_mode_uncached = 1'b0,
    e_cce_mode_normal   = 1'b1
  } bp_cce_mode_e;

  typedef enum logic [1:0] {
    e_lce_mode_uncached = 2'd0,
    e_lce_mode_normal   = 2'd1,
    e_lce_mode_nonspec  = 2'd2
  } bp_lce_mode_e;

  typedef enum logic [2:0] {
    e_cfg_none,
    e_cfg_freeze,
    e_cfg_core_id,
    e_cfg_cce_id,
    e_cfg_cce_mode,
    e_cfg_icache_mode,
    e_cfg_dcache_mode,
    e_cfg_ucode
  } bp_cfg_target_e;

  // Registers decode on an exact 16-bit match; the whole upper half is microcode.
  function automatic bp_cfg_target_e cfg_decode(input logic [15:0] addr);
    bp_cfg_target_e tgt;
    tgt = e_cfg_none;
    if ((addr & cfg_ucode_base_gp) != 16'h0000) begin
      tgt = e_cfg_ucode;
    end else begin
      case (addr)
        cfg_addr_freeze_gp:      tgt = e_cfg_freeze;
        cfg_addr_core_id_gp:     tgt = e_cfg_core_id;
        cfg_addr_cce_id_gp:      tgt = e_cfg_cce_id;
        cfg_addr_cce_mode_gp:    tgt = e_cfg_cce_mode;
        cfg_addr_icache_mode_gp: tgt = e_cfg_icache_mode;
        cfg_addr_dcache_mode_gp: tgt = e_cfg_dcache_mode;
        default:                 tgt = e_cfg_none;
      endcase
    end
    return tgt;
  endfunction

endpackage

// File: rtl/bp_cfg_cmd_responder.sv
// Tile config-space responder: one uncached command in, one response out.
// BP_CFG_RESP_READBACK_EN enables register/microcode readback (else reads return 0).
module bp_cfg_cmd_responder
  import bp_common_cfg_link_pkg::*;
#(
  parameter int core_id_width_p            = 8,
  parameter int cce_id_width_p             = 8,
  parameter int cce_instr_width_p          = 34,
  parameter int cce_instr_ram_addr_width_p = 8
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  bp_cce_mem_msg_s                       mem_cmd_i,
  input  logic                                  mem_cmd_v_i,
  output logic                                  mem_cmd_yumi_o,
  output bp_cce_mem_msg_s                       mem_resp_o,
  output logic                                  mem_resp_v_o,
  input  logic                                  mem_resp_ready_i,
  output logic                                  freeze_o,
  output logic [core_id_width_p-1:0]            core_id_o,
  output logic [cce_id_width_p-1:0]             cce_id_o,
  output logic                                  cce_mode_o,
  output logic [1:0]                            icache_mode_o,
  output logic [1:0]                            dcache_mode_o,
  output logic                                  cce_ucode_v_o,
  output logic                                  cce_ucode_w_o,
  output logic [cce_instr_ram_addr_width_p-1:0] cce_ucode_addr_o,
  output logic [cce_instr_width_p-1:0]          cce_ucode_data_o,
  input  logic [cce_instr_width_p-1:0]          cce_ucode_data_i
);

  typedef enum logic [1:0] {
    e_idle,
`ifdef BP_CFG_RESP_READBACK_EN
    e_ucode_rd,
`endif
    e_resp
  } state_e;

  state_e                     state_q, state_d;
  bp_cce_mem_msg_s            resp_q, resp_d;
  logic                       freeze_q, freeze_d;
  logic [core_id_width_p-1:0] core_id_q, core_id_d;
  logic [cce_id_width_p-1:0]  cce_id_q, cce_id_d;
  bp_cce_mode_e               cce_mode_q, cce_mode_d;
  bp_lce_mode_e               icache_mode_q, icache_mode_d;
  bp_lce_mode_e               dcache_mode_q, dcache_mode_d;

  bp_cfg_target_e tgt;
  logic           is_uc_wr;
  assign tgt      = cfg_decode(mem_cmd_i.addr[15:0]);
  assign is_uc_wr = (mem_cmd_i.msg_type == e_cce_mem_uc_wr);

`ifdef BP_CFG_RESP_READBACK_EN
  logic                          is_uc_rd;
  logic [cce_block_width_gp-1:0] rd_val;
  assign is_uc_rd = (mem_cmd_i.msg_type == e_cce_mem_uc_rd);

  always_comb begin
    rd_val = '0;
    case (tgt)
      e_cfg_freeze:      rd_val[0] = freeze_q;
      e_cfg_core_id:     rd_val[core_id_width_p-1:0] = core_id_q;
      e_cfg_cce_id:      rd_val[cce_id_width_p-1:0] = cce_id_q;
      e_cfg_cce_mode:    rd_val[0] = cce_mode_q;
      e_cfg_icache_mode: rd_val[1:0] = icache_mode_q;
      e_cfg_dcache_mode: rd_val[1:0] = dcache_mode_q;
      default:           rd_val = '0;
    endcase
  end
`else
  logic unused_ucode_rdata;
  assign unused_ucode_rdata = ^cce_ucode_data_i;
`endif

  always_comb begin
    state_d          = state_q;
    resp_d           = resp_q;
    freeze_d         = freeze_q;
    core_id_d        = core_id_q;
    cce_id_d         = cce_id_q;
    cce_mode_d       = cce_mode_q;
    icache_mode_d    = icache_mode_q;
    dcache_mode_d    = dcache_mode_q;
    mem_cmd_yumi_o   = 1'b0;
    cce_ucode_v_o    = 1'b0;
    cce_ucode_w_o    = 1'b0;
    cce_ucode_addr_o = '0;
    cce_ucode_data_o = '0;

    // Combinational handshakes are suppressed while reset is held.
    if (!reset_i) begin
      case (state_q)
        e_idle: begin
          mem_cmd_yumi_o = mem_cmd_v_i;
          if (mem_cmd_v_i) begin
            resp_d      = mem_cmd_i;
            resp_d.data = '0;
            state_d     = e_resp;
            if (is_uc_wr) begin
              case (tgt)
                e_cfg_freeze:      freeze_d      = mem_cmd_i.data[0];
                e_cfg_core_id:     core_id_d     = mem_cmd_i.data[core_id_width_p-1:0];
                e_cfg_cce_id:      cce_id_d      = mem_cmd_i.data[cce_id_width_p-1:0];
                e_cfg_cce_mode:    cce_mode_d    = bp_cce_mode_e'(mem_cmd_i.data[0]);
                e_cfg_icache_mode: icache_mode_d = bp_lce_mode_e'(mem_cmd_i.data[1:0]);
                e_cfg_dcache_mode: dcache_mode_d = bp_lce_mode_e'(mem_cmd_i.data[1:0]);
                e_cfg_ucode: begin
                  cce_ucode_v_o    = 1'b1;
                  cce_ucode_w_o    = 1'b1;
                  cce_ucode_addr_o = mem_cmd_i.addr[3 +: cce_instr_ram_addr_width_p];
                  cce_ucode_data_o = mem_cmd_i.data[cce_instr_width_p-1:0];
                end
                default: ;
              endcase
            end
`ifdef BP_CFG_RESP_READBACK_EN
            else if (is_uc_rd) begin
              if (tgt == e_cfg_ucode) begin
                cce_ucode_v_o    = 1'b1;
                cce_ucode_addr_o = mem_cmd_i.addr[3 +: cce_instr_ram_addr_width_p];
                state_d          = e_ucode_rd;
              end else begin
                resp_d.data = rd_val;
              end
            end
`endif
          end
        end
`ifdef BP_CFG_RESP_READBACK_EN
        e_ucode_rd: begin
          resp_d.data                        = '0;
          resp_d.data[cce_instr_width_p-1:0] = cce_ucode_data_i;
          state_d                            = e_resp;
        end
`endif
        e_resp: begin
          if (mem_resp_ready_i) state_d = e_idle;
        end
        default: state_d = e_idle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= e_idle;
      resp_q        <= '0;
      freeze_q      <= 1'b1;
      core_id_q     <= '0;
      cce_id_q      <= '0;
      cce_mode_q    <= e_cce_mode_uncached;
      icache_mode_q <= e_lce_mode_uncached;
      dcache_mode_q <= e_lce_mode_uncached;
    end else begin
      state_q       <= state_d;
      resp_q        <= resp_d;
      freeze_q      <= freeze_d;
      core_id_q     <= core_id_d;
      cce_id_q      <= cce_id_d;
      cce_mode_q    <= cce_mode_d;
      icache_mode_q <= icache_mode_d;
      dcache_mode_q <= dcache_mode_d;
    end
  end

  assign mem_resp_o    = resp_q;
  assign mem_resp_v_o  = (state_q == e_resp);
  assign freeze_o      = freeze_q;
  assign core_id_o     = core_id_q;
  assign cce_id_o      = cce_id_q;
  assign cce_mode_o    = cce_mode_q;
  assign icache_mode_o = icache_mode_q;
  assign dcache_mode_o = dcache_mode_q;

endmodule
